// File: rtl/div_unit.sv
// Multi-cycle 32-bit integer divider for the div/divu instructions.
// Produces {remainder, quotient} for the HI/LO registers using a restoring
// radix-2 algorithm on operand magnitudes. Signs are fixed up on completion.
// While a division is pending or running, stall freezes the upstream stages.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_div,
    input  logic        annul,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        ready,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic        neg_q;
    logic        neg_r;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] q_fin;
    logic [31:0] r_fin;
    logic        accept;

    assign accept = (state == IDLE) && start && !annul;

    // Operand magnitudes; in signed mode a negative operand is negated modulo 2^32,
    // so 0x80000000 maps to the unsigned magnitude 2^31.
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (signed_div && a[31]) begin
            a_mag = ~a + 32'd1;
        end
        if (signed_div && b[31]) begin
            b_mag = ~b + 32'd1;
        end
    end

    // One restoring step: shift the next dividend bit into the partial remainder
    // and keep the subtraction only when it does not go negative.
    always_comb begin
        rem_shift = {rem, quo[31]};
        diff      = rem_shift - {1'b0, dvs};
        fits      = ~diff[32];
        rem_nxt   = fits ? diff[31:0] : rem_shift[31:0];
        quo_nxt   = {quo[30:0], fits};
        q_fin     = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
        r_fin     = neg_r ? (~rem_nxt + 32'd1) : rem_nxt;
    end

    // Stall covers the request cycle itself plus every busy state, and is held low in reset.
    always_comb begin
        stall = resetn && (accept || (state == DIV_ON) || (state == DIV_ZERO));
    end

    // Control FSM with datapath registers; result only changes on completion or reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            quo    <= 32'd0;
            rem    <= 32'd0;
            dvs    <= 32'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= 64'h0;
            ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (accept) begin
                        quo   <= a_mag;
                        rem   <= 32'd0;
                        dvs   <= b_mag;
                        neg_q <= signed_div && (a[31] ^ b[31]);
                        neg_r <= signed_div && a[31];
                        cnt   <= 5'd0;
                        if (b == 32'd0) begin
                            state <= DIV_ZERO;
                        end else begin
                            state <= DIV_ON;
                        end
                    end
                end
                DIV_ZERO: begin
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        state  <= DIV_END;
                        result <= 64'h0;
                        ready  <= 1'b1;
                    end
                end
                DIV_ON: begin
                    if (annul) begin
                        state <= IDLE;
                        cnt   <= 5'd0;
                    end else begin
                        quo <= quo_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state  <= DIV_END;
                            result <= {r_fin, q_fin};
                            ready  <= 1'b1;
                        end
                    end
                end
                DIV_END: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: hand-computed quotient/remainder vectors,
// latency and stall profile, divide-by-zero, annul and asynchronous reset.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int checks   = 0;
    int failures = 0;

    div_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .a          (a),
        .b          (b),
        .result     (result),
        .ready      (ready),
        .stall      (stall)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one division, scramble the inputs after acceptance, then check
    // latency, stall profile, result and the one-cycle ready pulse.
    task automatic applyStimulus(input string tag, input logic sgn, input logic [31:0] da,
                                 input logic [31:0] db, input logic [63:0] exp_res);
        int lat;
        int got_lat;
        int stall_err;
        lat       = (db == 32'd0) ? 2 : 33;
        got_lat   = 0;
        stall_err = 0;
        @(negedge clk);
        start      = 1'b1;
        annul      = 1'b0;
        signed_div = sgn;
        a          = da;
        b          = db;
        #1;
        checkOutput({tag, "_stall_req"}, {63'd0, stall}, 64'd1);
        @(posedge clk);
        #1;
        start      = 1'b0;
        signed_div = ~sgn;
        a          = ~da;
        b          = db ^ 32'h5A5A_0001;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ready) begin
                got_lat = k;
                if (stall !== 1'b0) stall_err++;
                break;
            end
            if (stall !== 1'b1) stall_err++;
        end
        checkOutput({tag, "_latency"}, 64'(got_lat), 64'(lat));
        checkOutput({tag, "_result"}, result, exp_res);
        checkOutput({tag, "_stall_profile"}, 64'(stall_err), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_ready_drop"}, {63'd0, ready}, 64'd0);
        checkOutput({tag, "_result_hold"}, result, exp_res);
    endtask

    initial begin
        int ready_seen;
        resetn     = 1'b0;
        start      = 1'b1;
        signed_div = 1'b0;
        annul      = 1'b0;
        a          = 32'd9;
        b          = 32'd3;
        #12;
        checkOutput("reset_result", result, 64'h0);
        checkOutput("reset_ready", {63'd0, ready}, 64'd0);
        checkOutput("reset_stall", {63'd0, stall}, 64'd0);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        applyStimulus("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        applyStimulus("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        applyStimulus("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
        applyStimulus("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        applyStimulus("divu_min_max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);
        applyStimulus("divu_max_16", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF);
        applyStimulus("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E);
        applyStimulus("divu_3_5", 1'b0, 32'd3, 32'd5, 64'h00000003_00000000);
        applyStimulus("divu_5_0", 1'b0, 32'd5, 32'd0, 64'h0);
        applyStimulus("div_m9_0", 1'b1, 32'hFFFFFFF7, 32'd0, 64'h0);

        // Give result a non-zero value before the annul and reset scenarios.
        applyStimulus("divu_1000_10", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064);

        // start together with annul in IDLE must not be accepted.
        @(negedge clk);
        start = 1'b1;
        annul = 1'b1;
        a     = 32'd50;
        b     = 32'd5;
        #1;
        checkOutput("start_annul_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        checkOutput("start_annul_idle", {63'd0, stall}, 64'd0);

        // Annul on the 10th DIV_ON cycle.
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        a          = 32'd77;
        b          = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        @(negedge clk);
        checkOutput("annul_stall", {63'd0, stall}, 64'd0);
        ready_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready) ready_seen++;
        end
        checkOutput("annul_no_ready", 64'(ready_seen), 64'd0);
        checkOutput("annul_result_kept", result, 64'h00000000_00000064);
        applyStimulus("after_annul", 1'b0, 32'd77, 32'd3, 64'h00000002_00000019);

        // Asynchronous reset on the 20th DIV_ON cycle.
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b1;
        a          = 32'd1234;
        b          = 32'd11;
        @(posedge clk);
        #1;
        start = 1'b1;
        for (int k = 1; k < 20; k++) @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("midrst_result", result, 64'h0);
        checkOutput("midrst_ready", {63'd0, ready}, 64'd0);
        checkOutput("midrst_stall", {63'd0, stall}, 64'd0);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus("after_reset", 1'b1, 32'd1234, 32'd11, 64'h00000002_00000070);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always ends even if the DUT hangs.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
